tree_adder_sequential: RTL and testbench
========================================

TREE_ADDER_SEQUENTIAL -- requirements
Module: tree_adder_sequential

Interface
REQ-001 The block SHALL have parameter W_SMALL, default 4: width of operands a and b.
REQ-002 The block SHALL have parameter W_LARGE, default 8: width of operands c and d.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port a, input, W_SMALL bits: operand a, unsigned.
REQ-006 The block SHALL have port b, input, W_SMALL bits: operand b, unsigned.
REQ-007 The block SHALL have port c, input, W_LARGE bits: operand c, unsigned.
REQ-008 The block SHALL have port d, input, W_LARGE bits: operand d, unsigned.
REQ-009 The block SHALL have port in_valid, input, 1 bit: operands a..d are valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-011 The block SHALL have port sum1, output, W_SMALL+1 bits: a+b.
REQ-012 The block SHALL have port sum2, output, W_LARGE+1 bits: c+d.
REQ-013 The block SHALL have port sum3, output, W_LARGE+2 bits: sum1+sum2.
REQ-014 The block SHALL have port out_valid, output, 1 bit: sum1..sum3 hold a complete result.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-016 The block SHALL compute the three sums over three cycles using one shared adder of W_LARGE+2 bits, with narrower operands zero-extended; no overflow or wrap SHALL be possible.
REQ-017 The state machine SHALL have states IDLE, ADD_AB, ADD_CD, ADD_TOT and HOLD.
REQ-018 in_ready SHALL be high only in IDLE, so only one transaction is in flight.
REQ-019 On the edge where in_valid and in_ready are both high (edge E0), the block SHALL register a..d internally and go to ADD_AB.
REQ-020 On edge E1 the block SHALL register sum1 = a+b and go to ADD_CD.
REQ-021 On edge E2 the block SHALL register sum2 = c+d and go to ADD_TOT.
REQ-022 On edge E3 the block SHALL register sum3 = sum1+sum2, set out_valid and go to HOLD; latency is 3 cycles from acceptance to out_valid.
REQ-023 In HOLD, sum1..sum3 and out_valid SHALL stay stable while out_ready is low (backpressure of any length).
REQ-024 On the edge where out_valid and out_ready are both high, the block SHALL clear out_valid and go to IDLE, with in_ready high in the following cycle.
REQ-025 in_valid while busy (not IDLE) SHALL be ignored; operand changes after E0 SHALL not affect the result.
REQ-026 out_ready while out_valid is low SHALL have no effect.
REQ-027 sum1..sum3 SHALL be meaningful only while out_valid is high; between transactions they retain their last values until overwritten.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, with in_ready=1, out_valid=0 and sum1=sum2=sum3=0; the captured operands SHALL be cleared to 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no output handshake; the first edge after release with in_valid high SHALL start a fresh transaction.

Structure
REQ-030 Package tree_adder_pkg SHALL hold the state enumeration and the default width constants W_SMALL_DEF=4 and W_LARGE_DEF=8.
REQ-031 The shared adder SHALL be one sub-module, adder_unit, parameterised by width, combinational; the operand multiplexing and the FSM SHALL stay in tree_adder_sequential.

Verification
REQ-032 Basic: a=0, b=3, c=1, d=255 accepted with out_ready=1 -> out_valid exactly 3 cycles later, sum1=3, sum2=256, sum3=259.
REQ-033 Maximum values: a=15, b=15, c=255, d=255 -> sum1=30, sum2=510, sum3=540, with no truncation.
REQ-034 Backpressure: a=15, b=15, c=109, d=37 with out_ready=0 for 5 cycles -> sum1=30, sum2=146, sum3=176 held stable with out_valid high; transfer on the first out_ready=1 edge; in_ready high the next cycle.
REQ-035 Busy input ignored: after accepting a=10, b=13, c=9, d=10, drive a=0, b=9, c=45, d=45 with in_valid high -> in_ready low, first result 23/19/42; second set accepted only after return to IDLE, giving 9/90/99.
REQ-036 Reset mid-operation: assert rst while in ADD_CD -> outputs immediately 0, out_valid=0, in_ready=1; no result emitted for the aborted transaction.
REQ-037 Back-to-back: in_valid and out_ready held high with two operand sets -> one result every 5 cycles (accept, 3 compute, transfer), both correct.

Source files
------------

// File: rtl/tree_adder_pkg.sv
// Shared definitions for the sequential tree adder: FSM states and default operand widths.
package tree_adder_pkg;

  localparam int W_SMALL_DEF = 4;
  localparam int W_LARGE_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADD_AB,
    ADD_CD,
    ADD_TOT,
    HOLD
  } state_e;

endpackage

// File: rtl/adder_unit.sv
// Plain combinational adder, shared by every step of the tree addition.
module adder_unit #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/tree_adder_sequential.sv
// Computes a+b, c+d and their total over three cycles on one shared adder,
// with a valid/ready handshake on both the operand and the result side.
module tree_adder_sequential
  import tree_adder_pkg::*;
#(
  parameter int W_SMALL = W_SMALL_DEF,
  parameter int W_LARGE = W_LARGE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_SMALL-1:0] a,
  input  logic [W_SMALL-1:0] b,
  input  logic [W_LARGE-1:0] c,
  input  logic [W_LARGE-1:0] d,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [W_SMALL:0]   sum1,
  output logic [W_LARGE:0]   sum2,
  output logic [W_LARGE+1:0] sum3,
  output logic               out_valid,
  input  logic               out_ready
);

  // Wide enough for sum1+sum2, so no step of the tree can overflow.
  localparam int W_ADD = W_LARGE + 2;

  state_e             state_q, state_d;
  logic [W_SMALL-1:0] a_q, a_d, b_q, b_d;
  logic [W_LARGE-1:0] c_q, c_d, d_q, d_d;
  logic [W_SMALL:0]   sum1_q, sum1_d;
  logic [W_LARGE:0]   sum2_q, sum2_d;
  logic [W_LARGE+1:0] sum3_q, sum3_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [W_ADD-1:0]   op_a, op_b, add_sum;

  adder_unit #(.W(W_ADD)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    sum1_d      = sum1_q;
    sum2_d      = sum2_q;
    sum3_d      = sum3_q;
    out_valid_d = out_valid_q;
    op_a        = '0;
    op_b        = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = c;
          d_d     = d;
          state_d = ADD_AB;
        end
      end
      ADD_AB: begin
        op_a    = W_ADD'(a_q);
        op_b    = W_ADD'(b_q);
        sum1_d  = add_sum[W_SMALL:0];
        state_d = ADD_CD;
      end
      ADD_CD: begin
        op_a    = W_ADD'(c_q);
        op_b    = W_ADD'(d_q);
        sum2_d  = add_sum[W_LARGE:0];
        state_d = ADD_TOT;
      end
      ADD_TOT: begin
        op_a        = W_ADD'(sum1_q);
        op_b        = W_ADD'(sum2_q);
        sum3_d      = add_sum;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    // in_ready is registered, so it follows the state we are about to enter.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      sum1_q      <= '0;
      sum2_q      <= '0;
      sum3_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      sum1_q      <= sum1_d;
      sum2_q      <= sum2_d;
      sum3_q      <= sum3_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum1      = sum1_q;
  assign sum2      = sum2_q;
  assign sum3      = sum3_q;

endmodule

// File: tb/tb_tree_adder_sequential.sv
// Directed self-checking bench for tree_adder_sequential: latency, sums,
// backpressure, busy-input rejection, mid-transaction reset and back-to-back.
module tb_tree_adder_sequential;

   logic       clk;
   logic       rst;
   logic [3:0] a, b;
   logic [7:0] c, d;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] sum1;
   logic [8:0] sum2;
   logic [9:0] sum3;
   logic       out_valid;
   logic       out_ready;

   int checkCount;
   int errorCount;

   tree_adder_sequential #(.W_SMALL(4), .W_LARGE(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum1      (sum1),
      .sum2      (sum2),
      .sum3      (sum3),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Rising edge is active; the bench drives and samples on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present an operand set with in_valid high and step past the accepting edge.
   task automatic applyStimulus(input logic [3:0] ia, input logic [3:0] ib,
                                input logic [7:0] ic, input logic [7:0] id);
      a        = ia;
      b        = ib;
      c        = ic;
      d        = id;
      in_valid = 1'b1;
      @(negedge clk);
   endtask

   // Wait (bounded) for out_valid after acceptance, then check latency and sums.
   task automatic waitResult(input string tag, input int e1, input int e2, input int e3);
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput({tag, "_latency"}, cnt, 3);
      checkOutput({tag, "_sum1"}, sum1, e1);
      checkOutput({tag, "_sum2"}, sum2, e2);
      checkOutput({tag, "_sum3"}, sum3, e3);
   endtask

   // After the transfer edge the block must be back in IDLE.
   task automatic checkReleased(input string tag);
      @(negedge clk);
      checkOutput({tag, "_out_valid_clr"}, out_valid, 0);
      checkOutput({tag, "_in_ready_set"}, in_ready, 1);
   endtask

   initial begin
      int cnt;
      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      a          = '0;
      b          = '0;
      c          = '0;
      d          = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;

      // Reset values.
      @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_sum1", sum1, 0);
      checkOutput("rst_sum2", sum2, 0);
      checkOutput("rst_sum3", sum3, 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic transaction.
      applyStimulus(4'd0, 4'd3, 8'd1, 8'd255);
      in_valid = 1'b0;
      checkOutput("basic_in_ready_busy", in_ready, 0);
      waitResult("basic", 3, 256, 259);
      checkReleased("basic");

      // Maximum operands, no truncation.
      applyStimulus(4'd15, 4'd15, 8'd255, 8'd255);
      in_valid = 1'b0;
      waitResult("max", 30, 510, 540);
      checkReleased("max");

      // Backpressure for 5 cycles.
      out_ready = 1'b0;
      applyStimulus(4'd15, 4'd15, 8'd109, 8'd37);
      in_valid = 1'b0;
      waitResult("bp", 30, 146, 176);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_hold_valid", out_valid, 1);
         checkOutput("bp_hold_sum1", sum1, 30);
         checkOutput("bp_hold_sum2", sum2, 146);
         checkOutput("bp_hold_sum3", sum3, 176);
      end
      out_ready = 1'b1;
      checkReleased("bp");

      // Busy input ignored; second set only taken after returning to IDLE.
      applyStimulus(4'd10, 4'd13, 8'd9, 8'd10);
      a = 4'd0;
      b = 4'd9;
      c = 8'd45;
      d = 8'd45;
      checkOutput("busy_in_ready", in_ready, 0);
      waitResult("busy_first", 23, 19, 42);
      checkReleased("busy");
      @(negedge clk);
      in_valid = 1'b0;
      waitResult("busy_second", 9, 90, 99);
      checkReleased("busy_second");

      // Reset while in ADD_CD aborts the transaction.
      applyStimulus(4'd5, 4'd6, 8'd7, 8'd8);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort_sum1_pre", sum1, 11);
      rst = 1'b1;
      #1;
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_in_ready", in_ready, 1);
      checkOutput("abort_sum1", sum1, 0);
      checkOutput("abort_sum2", sum2, 0);
      checkOutput("abort_sum3", sum3, 0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      checkOutput("abort_no_result", cnt, 0);
      applyStimulus(4'd1, 4'd2, 8'd3, 8'd4);
      in_valid = 1'b0;
      waitResult("post_abort", 3, 7, 10);
      checkReleased("post_abort");

      // Back-to-back with in_valid and out_ready held high.
      applyStimulus(4'd7, 4'd8, 8'd100, 8'd200);
      a = 4'd2;
      b = 4'd4;
      c = 8'd128;
      d = 8'd127;
      waitResult("b2b_first", 15, 300, 315);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!out_valid && cnt < 12);
      in_valid = 1'b0;
      checkOutput("b2b_period", cnt, 5);
      checkOutput("b2b_second_sum1", sum1, 6);
      checkOutput("b2b_second_sum2", sum2, 255);
      checkOutput("b2b_second_sum3", sum3, 261);
      checkReleased("b2b");

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
